// File: rtl/mips_ops_pkg.sv
// Shared operation encodings, FSM states and iteration count for the HI/LO unit.
package mips_ops_pkg;

    localparam int HILO_ITER = 32;

    localparam logic [4:0] OP_DIV   = 5'b01111;
    localparam logic [4:0] OP_DIVU  = 5'b10000;
    localparam logic [4:0] OP_MULT  = 5'b10001;
    localparam logic [4:0] OP_MULTU = 5'b10010;
    localparam logic [4:0] OP_MFHI  = 5'b10011;
    localparam logic [4:0] OP_MFLO  = 5'b10100;
    localparam logic [4:0] OP_MTHI  = 5'b10101;
    localparam logic [4:0] OP_MTLO  = 5'b10111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } hilo_state_e;

    // True for any operation code the HI/LO unit owns.
    function automatic logic is_hilo_op(input logic [4:0] op);
        logic hit;
        hit = 1'b0;
        case (op)
            OP_DIV, OP_DIVU, OP_MULT, OP_MULTU,
            OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: hit = 1'b1;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/hilo_iter_core.sv
// Shift-add multiply / restoring divide datapath on unsigned magnitudes.
// Multiply: {acc_hi,acc_lo} starts as {0, multiplier}; ends as the 64-bit product.
// Divide:   acc_hi is the partial remainder, acc_lo shifts the dividend out
//           and the quotient bits in; ends as {remainder, quotient}.
module hilo_iter_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        div_mode_in,
    input  logic        step,
    input  logic [31:0] a_in,
    input  logic [31:0] b_in,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] opnd;
    logic        div_mode;
    logic [32:0] mul_sum;
    logic [32:0] div_shift;
    logic [32:0] div_diff;

    // Single-step add (multiply) and trial subtract (divide).
    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : 33'd0);
        div_shift = {acc_hi, acc_lo[31]};
        div_diff  = div_shift - {1'b0, opnd};
    end

    // Accumulator/remainder registers: load on accept, one step per busy cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hi   <= '0;
            acc_lo   <= '0;
            opnd     <= '0;
            div_mode <= 1'b0;
        end else if (load) begin
            acc_hi   <= '0;
            div_mode <= div_mode_in;
            if (div_mode_in) begin
                acc_lo <= a_in;
                opnd   <= b_in;
            end else begin
                acc_lo <= b_in;
                opnd   <= a_in;
            end
        end else if (step) begin
            if (div_mode) begin
                if (!div_diff[32]) begin
                    acc_hi <= div_diff[31:0];
                    acc_lo <= {acc_lo[30:0], 1'b1};
                end else begin
                    acc_hi <= div_shift[31:0];
                    acc_lo <= {acc_lo[30:0], 1'b0};
                end
            end else begin
                acc_hi <= mul_sum[32:1];
                acc_lo <= {mul_sum[0], acc_lo[31:1]};
            end
        end
    end

    assign hi_out = acc_hi;
    assign lo_out = acc_lo;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative multiply/divide for the EX stage.
// Handshake: a HI/LO op (op_valid high, recognised code) is consumed at the
// rising edge where stall is low; while stall is high the op has no effect and
// the pipeline must hold it. Non-HI/LO codes never stall and are ignored.
module hilo_muldiv_unit
    import mips_ops_pkg::*;
#(
    parameter int ITER = HILO_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [4:0]  operation,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hilo_rdata,
    output logic        stall,
    output logic        busy,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MUL  = ST_MUL;
    localparam logic [1:0] S_DIV  = ST_DIV;
    localparam logic [1:0] S_FIX  = ST_FIX;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] hi_q, lo_q;
    logic        neg_q, neg_r, dz_q;
    logic [31:0] rs_hold;

    logic        hilo_op, accept, start_mul, start_div, signed_op;
    logic [31:0] a_mag, b_mag;
    logic [31:0] core_hi, core_lo;
    logic [63:0] product, product_fix;
    logic [31:0] fix_hi, fix_lo;

    // Decode, stall and operand magnitude preparation.
    always_comb begin
        hilo_op   = op_valid && is_hilo_op(operation);
        busy      = (state != S_IDLE);
        stall     = hilo_op && busy;
        accept    = op_valid && !busy;
        start_mul = accept && (operation == OP_MULT || operation == OP_MULTU);
        start_div = accept && (operation == OP_DIV  || operation == OP_DIVU);
        signed_op = (operation == OP_MULT) || (operation == OP_DIV);
        a_mag     = (signed_op && rs_val[31]) ? (~rs_val + 32'd1) : rs_val;
        b_mag     = (signed_op && rt_val[31]) ? (~rt_val + 32'd1) : rt_val;
        hilo_rdata = 32'd0;
        if (accept && operation == OP_MFHI) hilo_rdata = hi_q;
        if (accept && operation == OP_MFLO) hilo_rdata = lo_q;
    end

    hilo_iter_core u_core (
        .clk         (clk),
        .rst         (rst),
        .load        (start_mul || start_div),
        .div_mode_in (start_div),
        .step        (state == S_MUL || state == S_DIV),
        .a_in        (a_mag),
        .b_in        (b_mag),
        .hi_out      (core_hi),
        .lo_out      (core_lo)
    );

    // Sign fixup of the raw magnitude result; divide-by-zero overrides it.
    always_comb begin
        product     = {core_hi, core_lo};
        product_fix = neg_q ? (~product + 64'd1) : product;
        fix_hi      = product_fix[63:32];
        fix_lo      = product_fix[31:0];
        if (state == S_FIX && cnt == 5'd1) begin
            fix_lo = neg_q ? (~core_lo + 32'd1) : core_lo;
            fix_hi = neg_r ? (~core_hi + 32'd1) : core_hi;
            if (dz_q) begin
                fix_hi = rs_hold;
                fix_lo = 32'hFFFF_FFFF;
            end
        end
    end

    // FSM and iteration counter; cnt is reused in FIX to mark a divide result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start_mul) state <= S_MUL;
                    if (start_div) state <= S_DIV;
                end
                S_MUL, S_DIV: begin
                    if (cnt == 5'(ITER - 1)) begin
                        state <= S_FIX;
                        cnt   <= (state == S_DIV) ? 5'd1 : 5'd0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sign bookkeeping and divide-by-zero flag captured on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dz_q        <= 1'b0;
            rs_hold     <= '0;
            div_by_zero <= 1'b0;
        end else if (start_mul || start_div) begin
            neg_q   <= signed_op && (rs_val[31] ^ rt_val[31]);
            neg_r   <= signed_op && rs_val[31];
            dz_q    <= start_div && (rt_val == 32'd0);
            rs_hold <= rs_val;
            if (start_div) div_by_zero <= (rt_val == 32'd0);
        end
    end

    // HI/LO registers: result at end of FIX, direct moves when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == S_FIX) begin
            hi_q <= fix_hi;
            lo_q <= fix_lo;
        end else if (accept && operation == OP_MTHI) begin
            hi_q <= rs_val;
        end else if (accept && operation == OP_MTLO) begin
            lo_q <= rs_val;
        end
    end

    assign state_dbg = state;

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit owning the HI/LO register pair of the pipelined MIPS core. It sits in the EX stage beside the ALU and accepts the HI/LO operation codes produced by the control unit: div, divu, mult, multu, mfhi, mflo, mthi and mtlo. It sequences a 32-iteration shift-add/shift-subtract datapath and applies a sign-fixup cycle. While busy, it stalls the pipeline on any dependent HI/LO instruction.

## Interface
- `ITER`, default 32: number of iteration cycles. Must equal the operand width. Fixed at 32.
- `clk`, input, 1: rising-edge clock.
- `rst`, input, 1: asynchronous, active-high reset.
- `op_valid`, input, 1: EX-stage instruction is valid and not flushed.
- `operation`, input, 5: control-unit operation code. 5'b01111 div, 5'b10000 divu, 5'b10001 mult, 5'b10010 multu, 5'b10011 mfhi, 5'b10100 mflo, 5'b10101 mthi, 5'b10111 mtlo. All other codes are ignored.
- `rs_val`, input, 32: first operand (dividend / multiplicand / mthi-mtlo source).
- `rt_val`, input, 32: second operand (divisor / multiplier).
- `hilo_rdata`, output, 32: HI for mfhi, LO for mflo, otherwise 0.
- `stall`, output, 1: combinational. Holds the IF/ID/EX stages.
- `busy`, output, 1: an operation is in flight.
- `div_by_zero`, output, 1: sticky until the next div/divu is accepted. Set when the accepted divisor was 0.

## Operation
- A HI/LO op is an op with `op_valid` high and a recognised code.
- `stall` = HI/LO op && `busy`. A stalled op is not accepted and has no effect.
- In IDLE with `busy` low:
  - mult/multu/div/divu is accepted at the clock edge. Operands are latched as magnitudes; signed variants use two's-complement absolute values, unsigned variants use them raw. Result signs are recorded. The FSM goes to MUL or DIV.
  - mthi/mtlo writes `rs_val` into HI/LO at the edge.
  - mfhi/mflo drives `hilo_rdata` combinationally from the current HI/LO.
- FSM states:
  - IDLE.
  - MUL: 32 cycles. Add the multiplicand if the multiplier LSB is 1, then shift the 64-bit accumulator right.
  - DIV: 32 cycles. Restoring divide: shift the remainder left, try subtract, set the quotient bit.
  - FIX: 1 cycle, then return to IDLE.
- A 5-bit iteration counter clears on accept and increments each MUL/DIV cycle. The transition MUL/DIV -> FIX happens at count 31.
- In FIX, HI/LO are written:
  - mult: {HI,LO} = 64-bit product, negated (64-bit) if the operand signs differ.
  - div: LO = quotient, negated if the signs differ. HI = remainder, with the sign of `rs_val`.
  - div/divu with `rt_val`=0: HI = `rs_val`, LO = 32'hFFFF_FFFF, `div_by_zero`=1. The FSM still runs the full sequence.
  - div of 32'h8000_0000 by 32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- `operation` and the operands are don't-care outside accept cycles. They are not re-sampled during MUL/DIV/FIX.

## Timing
- Reset values: HI=0, LO=0, FSM=IDLE, counter=0, `busy`=0, `stall`=0, `div_by_zero`=0, `hilo_rdata`=0.
- Accept at edge N. `busy`=1 from N through edge N+33. HI/LO are updated at edge N+33 (the end of FIX). `busy`=0 after N+33.
- mfhi issued in the cycle after edge N+33 reads the new value with no stall. Latency from accept to readable result is 34 cycles.
- mthi/mtlo and mfhi/mflo when idle: zero stall. mthi takes effect at the same edge. mfhi in the following cycle sees it.
- Back-to-back mult: the second op stalls 33 cycles and is accepted at edge N+33. FIX completion and the new accept coincide legally. The new op's operands are latched while HI/LO take the old result.
- `rst` asserted mid-operation aborts immediately. The partial result is discarded and HI/LO are cleared.
- `op_valid` low (flush) when `busy`: `stall`=0, and the in-flight operation continues.

## Structure
- Shared package `mips_ops_pkg` holds:
  - the 5-bit operation encodings, shared with the control decoder;
  - the FSM state enum (IDLE, MUL, DIV, FIX);
  - the ITER constant.
- One sub-module, `hilo_iter_core`, holds the accumulator/remainder shift registers and the single-step add/subtract. The FSM, counter, sign bookkeeping, HI/LO registers and stall logic stay in the top level.

## Test plan
- Reset, then mfhi and mflo -> `hilo_rdata`=0, `stall`=0.
- mult with rs=32'hFFFF_FFFE (-2) and rt=3 -> 33 stall cycles for a following mflo. Then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA. multu with the same operands -> HI=2, LO=32'hFFFF_FFFA.
- div with rs=-7 and rt=2 -> LO=32'hFFFF_FFFD (-3), HI=32'hFFFF_FFFF (-1). divu with rs=7 and rt=2 -> LO=3, HI=1.
- div with rt=0 and rs=5 -> HI=5, LO=32'hFFFF_FFFF, `div_by_zero`=1. A following valid div clears the flag on accept.
- mthi 32'hA5A5_A5A5 when idle, mfhi next cycle -> 32'hA5A5_A5A5 with no stall. mtlo issued while busy -> stalled until `busy` falls, then written.
- `rst` pulse at iteration 10 of a mult -> `busy`=0 and HI=LO=0 immediately. A new mult after release completes correctly in 34 cycles.
